// File: rtl/port_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM state codes,
// tx_ctrl / tx_status bit positions, the debug view type and the status packer.
package port_uart_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam int CTRL_TOGGLE = 0;
   localparam int CTRL_FLUSH  = 1;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;

   typedef struct packed {
      logic [1:0] state;
      logic [2:0] bit_idx;
   } tx_dbg_t;

   function automatic logic [7:0] pack_status(input logic [2:0] count,
                                              input logic       ovf,
                                              input logic       busy,
                                              input logic       full,
                                              input logic       empty);
      logic [7:0] s;
      s = '0;
      s[STAT_EMPTY] = empty;
      s[STAT_FULL]  = full;
      s[STAT_BUSY]  = busy;
      s[STAT_OVF]   = ovf;
      s[STAT_CNT_LSB +: 3] = count;
      return s;
   endfunction

endpackage

// File: rtl/port_uart_tx_if.sv
// Port-side bundle of the UART transmitter: CPU output/input port wiring,
// the serial line and a debug view of the FSM.
interface port_uart_tx_if;

   // Enqueue protocol: the CPU writes tx_data first, then flips tx_ctrl[0];
   // every flip (either direction) is one push, sampled together with tx_data
   // on the same rising edge. There is no ready: software polls tx_status.
   logic [7:0]                  tx_data;
   logic [7:0]                  tx_ctrl;
   logic [7:0]                  tx_status;
   logic                        tx;
   port_uart_tx_pkg::tx_dbg_t   dbg;

   modport master (
      output tx_data,
      output tx_ctrl,
      input  tx_status,
      input  tx,
      input  dbg
   );

   modport slave (
      input  tx_data,
      input  tx_ctrl,
      output tx_status,
      output tx,
      output dbg
   );

endinterface

// File: rtl/port_tx_fifo.sv
// Synchronous DEPTH x 8 byte FIFO with flush; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module port_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic [2:0] count,
   output logic       full,
   output logic       empty
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [2:0]    cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == 3'd0);
   assign full    = (cnt == DEPTH_C);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Flush wins over everything, including a push on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= 3'd0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= 3'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + {2'b00, do_push} - {2'b00, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/port_uart_tx.sv
// 8N1 serial transmitter fed by CPU output ports: toggle-edge enqueue, byte
// FIFO, frame FSM with baud/bit counters, and a pollable status byte.
module port_uart_tx
   import port_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH        = 4
) (
   input  logic            clk,
   input  logic            reset,
   port_uart_tx_if.slave   bus
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   logic [1:0]    state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shifter;
   logic          tx_q;
   logic          tog_q;
   logic          overflow;

   logic          push_req;
   logic          flush;
   logic          pop;
   logic          baud_done;
   logic [7:0]    fifo_rdata;
   logic [2:0]    fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          unused_ctrl;

   assign push_req    = bus.tx_ctrl[CTRL_TOGGLE] ^ tog_q;
   assign flush       = bus.tx_ctrl[CTRL_FLUSH];
   assign pop         = (state == ST_IDLE) && !fifo_empty && !flush;
   assign baud_done   = (baud == BAUD_LAST);
   assign unused_ctrl = &{1'b0, bus.tx_ctrl[7:2]};

   port_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .flush (flush),
      .wdata (bus.tx_data),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Toggle history and sticky overflow; a push dropped by flush is not an overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tog_q    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         tog_q <= bus.tx_ctrl[CTRL_TOGGLE];
         if (flush) begin
            overflow <= 1'b0;
         end else if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= 3'd0;
         shifter <= 8'h00;
         tx_q    <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shifter <= fifo_rdata;
                  tx_q    <= 1'b0;
                  baud    <= '0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud    <= '0;
                  bit_idx <= 3'd0;
                  tx_q    <= shifter[0];
                  state   <= ST_DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     tx_q  <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     // Next bit is shifter[1] because the shift lands on this same edge.
                     shifter <= shifter >> 1;
                     tx_q    <= shifter[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_done) begin
                  baud  <= '0;
                  state <= ST_IDLE;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.tx          = tx_q;
   assign bus.tx_status   = pack_status(fifo_count, overflow, (state != ST_IDLE),
                                        fifo_full, fifo_empty);
   assign bus.dbg.state   = state;
   assign bus.dbg.bit_idx = bit_idx;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: directed scenarios plus random traffic, checked each
// cycle against a frame-timing model of the line and FIFO status.
module tb_port_uart_tx;

   localparam int CPB   = 16;
   localparam int CPB2  = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   port_uart_tx_if bus ();
   port_uart_tx_if bus2 ();

   port_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   port_uart_tx #(.CLKS_PER_BIT(CPB2), .DEPTH(DEPTH)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // Model: queued bytes, the frame being sent and its cycle offset.
   logic [7:0] exp_q[$];
   logic       m_hist;
   logic       m_ovf;
   logic       m_active;
   int         m_t;
   logic [7:0] m_cur;

   task automatic model_reset();
      exp_q.delete();
      m_hist   = 1'b0;
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_t      = 0;
      m_cur    = 8'h00;
   endtask

   task automatic model_step(input logic [7:0] ctrl, input logic [7:0] data);
      logic push_req, flush, pre_active, pop;
      int   n_pre;
      push_req   = (ctrl[0] != m_hist);
      m_hist     = ctrl[0];
      flush      = ctrl[1];
      pre_active = m_active;
      n_pre      = exp_q.size();
      if (m_active) begin
         m_t++;
         if (m_t == 10 * CPB) m_active = 1'b0;
      end
      if (flush) begin
         exp_q.delete();
         m_ovf = 1'b0;
      end else begin
         pop = !pre_active && (n_pre > 0);
         if (pop) begin
            m_cur    = exp_q.pop_front();
            m_active = 1'b1;
            m_t      = 0;
         end
         if (push_req) begin
            if (n_pre < DEPTH || pop) exp_q.push_back(data);
            else m_ovf = 1'b1;
         end
      end
   endtask

   function automatic logic m_line();
      int b;
      if (!m_active) return 1'b1;
      b = m_t / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_cur[b-1];
      return 1'b1;
   endfunction

   function automatic logic [7:0] m_status();
      int         n;
      logic [2:0] c;
      n = exp_q.size();
      c = n[2:0];
      return {1'b0, c, m_ovf, m_active, (n == DEPTH), (n == 0)};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (!reset) model_reset();
         else model_step(bus.tx_ctrl, bus.tx_data);
         #1;
         check("line", {7'b0, bus.tx}, {7'b0, m_line()});
         check("status", bus.tx_status, m_status());
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic toggle(input logic [7:0] d);
      bus.tx_data    = d;
      bus.tx_ctrl[0] = ~bus.tx_ctrl[0];
      tick();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i;
      i = 0;
      while (i < budget && (bus.tx_status[2] || !bus.tx_status[0])) begin
         tick();
         i++;
      end
      check(name, {7'b0, (i < budget)}, 8'h01);
   endtask

   initial begin
      logic [9:0] pat;
      logic [9:0] pat2;
      int         t;
      int         rate;

      // Reset state with all output ports cleared
      reset         = 1'b0;
      bus.tx_data   = 8'h00;
      bus.tx_ctrl   = 8'h00;
      bus2.tx_data  = 8'h00;
      bus2.tx_ctrl  = 8'h00;
      repeat (3) tick();
      check("reset_tx", {7'b0, bus.tx}, 8'h01);
      check("reset_status", bus.tx_status, 8'h01);
      check("reset_status2", bus2.tx_status, 8'h01);
      reset = 1'b1;
      tick();

      // Single byte 0xA5: start, LSB-first data, stop
      pat = {1'b1, 8'hA5, 1'b0};
      toggle(8'hA5);
      check("a5_pre_start", {7'b0, bus.tx}, 8'h01);
      tick();
      t = 0;
      for (int i = 0; i < 10; i++) begin
         while (t < CPB * i + CPB / 2) begin
            tick();
            t++;
         end
         check($sformatf("a5_bit%0d", i), {7'b0, bus.tx}, {7'b0, pat[i]});
         check($sformatf("a5_busy%0d", i), {7'b0, bus.tx_status[2]}, 8'h01);
      end
      while (t < 10 * CPB - 1) begin
         tick();
         t++;
      end
      check("a5_last_busy", bus.tx_status, 8'h05);
      tick();
      check("a5_done", bus.tx_status, 8'h01);

      // Five quick bytes fill the FIFO, a sixth overflows
      for (int i = 1; i <= 5; i++) toggle(8'(i));
      check("fill_status", bus.tx_status, 8'h46);
      toggle(8'h06);
      check("overflow_status", bus.tx_status, 8'h4E);
      wait_idle("drain_burst", 6 * (10 * CPB + 1) + 20);
      check("burst_end_status", bus.tx_status, 8'h09);

      // Flush mid-frame with a toggle on the same edge
      toggle(8'h11);
      toggle(8'h22);
      toggle(8'h33);
      check("preflush_status", bus.tx_status, 8'h2C);
      repeat (20) tick();
      bus.tx_ctrl[1] = 1'b1;
      toggle(8'h44);
      check("flush_status", bus.tx_status, 8'h05);
      bus.tx_ctrl[1] = 1'b0;
      tick();
      wait_idle("drain_flush", 10 * CPB + 20);
      check("flush_end_status", bus.tx_status, 8'h01);

      // Push into a full FIFO on the exact edge the IDLE state pops
      for (int i = 0; i < 5; i++) toggle(8'hA1 + 8'(i));
      t = 0;
      while (t < 10 * CPB + 10 && bus.tx_status[2]) begin
         tick();
         t++;
      end
      check("idle_gap_status", bus.tx_status, 8'h42);
      toggle(8'hB6);
      check("pop_push_status", bus.tx_status, 8'h46);
      wait_idle("drain_full", 6 * (10 * CPB + 1) + 20);
      check("full_end_status", bus.tx_status, 8'h01);

      // Reset in the middle of a frame drives the line high at once
      toggle(8'h5A);
      repeat (40) tick();
      check("midframe_busy", {7'b0, bus.tx_status[2]}, 8'h01);
      #2 reset = 1'b0;
      #1;
      check("midframe_reset_tx", {7'b0, bus.tx}, 8'h01);
      check("midframe_reset_status", bus.tx_status, 8'h01);
      bus.tx_ctrl = 8'h00;
      tick();
      reset = 1'b1;
      tick();

      // Random traffic: sparse then dense, rare flushes, noise on ignored ctrl bits
      for (int c = 0; c < 3000; c++) begin
         rate = (c < 1500) ? 1 : 8;
         bus.tx_ctrl[7:2] = 6'($urandom_range(0, 63));
         bus.tx_ctrl[1]   = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) < rate) begin
            bus.tx_data    = 8'($urandom_range(0, 255));
            bus.tx_ctrl[0] = ~bus.tx_ctrl[0];
         end
         tick();
      end
      bus.tx_ctrl[7:1] = 7'h00;
      wait_idle("drain_random", 6 * (10 * CPB + 1) + 20);

      // CLKS_PER_BIT=2 instance: 20-cycle frame
      pat2 = {1'b1, 8'h3C, 1'b0};
      bus2.tx_data    = 8'h3C;
      bus2.tx_ctrl[0] = 1'b1;
      tick();
      check("cpb2_pre_start", {7'b0, bus2.tx}, 8'h01);
      tick();
      for (int i = 0; i < 20; i++) begin
         check($sformatf("cpb2_t%0d", i), {7'b0, bus2.tx}, {7'b0, pat2[i / CPB2]});
         check($sformatf("cpb2_stat%0d", i), bus2.tx_status, 8'h05);
         tick();
      end
      check("cpb2_done", bus2.tx_status, 8'h01);
      check("cpb2_idle_tx", {7'b0, bus2.tx}, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
